// File: rtl/spwtcr_pkg.sv
// rtl/spwtcr_pkg.sv - shared SpaceWire character constants
package spwtcr_pkg;
    localparam int SPW_CHAR_W = 9;
    localparam logic [SPW_CHAR_W-1:0] SPW_EOP = 9'h100;
    localparam logic [SPW_CHAR_W-1:0] SPW_EEP = 9'h101;
    localparam int SPW_FCT_CREDIT = 8;
endpackage

// File: rtl/spwtcr_dp_ram.sv
// rtl/spwtcr_dp_ram.sv - DEPTH x W storage, synchronous write, asynchronous read
module spwtcr_dp_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int W      = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/spwtcr_rx_fifo.sv
// rtl/spwtcr_rx_fifo.sv - receive N-Char buffer with packet counting and flush
module spwtcr_rx_fifo
    import spwtcr_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - SPW_FCT_CREDIT
) (
    input  logic                  CLOCK,
    input  logic                  RESETn,
    input  logic                  flush,
    input  logic [SPW_CHAR_W-1:0] RX_DATA,
    input  logic                  BUFFER_WRITE,
    output logic                  BUFFER_READY,
    output logic                  almost_full,
    output logic [SPW_CHAR_W-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [ADDR_W:0]       count,
    output logic [ADDR_W:0]       pkt_count,
    output logic                  overflow
);
    localparam logic [ADDR_W:0]   FULL_N = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_N   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR1   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              full;
    logic              wr_acc, pop;
    logic              pkt_in, pkt_out;

    // Flags come only from the registered count so the receiver sees no input-to-output path.
    assign full         = (count == FULL_N);
    assign BUFFER_READY = !full;
    assign RD_VALID     = (count != '0);
    assign almost_full  = (count >= AF_N);

    assign wr_acc  = BUFFER_WRITE && !full && !flush;
    assign pop     = RD_VALID && RD_READY && !flush;
    assign pkt_in  = wr_acc && RX_DATA[8];
    assign pkt_out = pop && RD_DATA[8];

    spwtcr_dp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (SPW_CHAR_W)
    ) u_ram (
        .clk   (CLOCK),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (RX_DATA),
        .raddr (rd_ptr),
        .rdata (RD_DATA)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESETn || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= BUFFER_WRITE && full;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_spwtcr_rx_fifo.sv
// tb/tb_spwtcr_rx_fifo.sv - directed scoreboard bench for spwtcr_rx_fifo
module tb_spwtcr_rx_fifo;
    import spwtcr_pkg::*;

    localparam int DEPTH = 64;

    logic       CLOCK = 1'b0;
    logic       RESETn;
    logic       flush;
    logic [8:0] RX_DATA;
    logic       BUFFER_WRITE;
    logic       BUFFER_READY;
    logic       almost_full;
    logic [8:0] RD_DATA;
    logic       RD_VALID;
    logic       RD_READY;
    logic [6:0] count;
    logic [6:0] pkt_count;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    int         m_pkt = 0;
    logic       m_ovf = 1'b0;

    always #5 CLOCK = ~CLOCK;

    spwtcr_rx_fifo dut (
        .CLOCK        (CLOCK),
        .RESETn       (RESETn),
        .flush        (flush),
        .RX_DATA      (RX_DATA),
        .BUFFER_WRITE (BUFFER_WRITE),
        .BUFFER_READY (BUFFER_READY),
        .almost_full  (almost_full),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .RD_READY     (RD_READY),
        .count        (count),
        .pkt_count    (pkt_count),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = sb.size();
        check("count", 32'(count), 32'(sz));
        check("pkt_count", 32'(pkt_count), 32'(m_pkt));
        check("rd_valid", 32'(RD_VALID), 32'(sz != 0));
        check("buffer_ready", 32'(BUFFER_READY), 32'(sz < DEPTH));
        check("almost_full", 32'(almost_full), 32'(sz >= 56));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock of stimulus; the queue predicts what is stored and what pops out.
    task automatic cycle(input logic wr, input logic [8:0] d, input logic rdy, input logic fl);
        logic [8:0] e;
        int sz;
        BUFFER_WRITE = wr;
        RX_DATA      = d;
        RD_READY     = rdy;
        flush        = fl;
        sz    = sb.size();
        m_ovf = 1'b0;
        if (fl) begin
            sb.delete();
            m_pkt = 0;
        end else begin
            if (rdy && sz > 0) begin
                e = sb.pop_front();
                check("rd_data", 32'(RD_DATA), 32'(e));
                if (e[8]) m_pkt--;
            end
            if (wr) begin
                if (sz < DEPTH) begin
                    sb.push_back(d);
                    if (d[8]) m_pkt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge CLOCK);
        #1;
        BUFFER_WRITE = 1'b0;
        RD_READY     = 1'b0;
        flush        = 1'b0;
        RX_DATA      = 9'bx;
        check_state();
    endtask

    initial begin
        RESETn = 1'b0; flush = 1'b0; BUFFER_WRITE = 1'b0; RD_READY = 1'b0; RX_DATA = 9'bx;
        repeat (2) @(posedge CLOCK);
        #1;
        RESETn = 1'b1;
        check_state();
        cycle(1'b0, 9'h000, 1'b0, 1'b0);

        // Small packet, then drain
        cycle(1'b1, 9'h041, 1'b0, 1'b0);
        check("first_rd_data", 32'(RD_DATA), 32'h041);
        cycle(1'b1, 9'h0A5, 1'b0, 1'b0);
        cycle(1'b1, SPW_EOP, 1'b0, 1'b0);
        check("pkt_after_eop", 32'(pkt_count), 32'd1);
        check("count_after_3", 32'(count), 32'd3);
        repeat (3) cycle(1'b0, 9'h000, 1'b1, 1'b0);
        check("drained_pkt", 32'(pkt_count), 32'd0);

        // Fill to almost_full, then full, then overflow with a simultaneous pop
        for (int i = 0; i < 55; i++) cycle(1'b1, 9'(i), 1'b0, 1'b0);
        check("af_at_55", 32'(almost_full), 32'd0);
        cycle(1'b1, 9'h037, 1'b0, 1'b0);
        check("af_at_56", 32'(almost_full), 32'd1);
        for (int i = 56; i < 64; i++) cycle(1'b1, 9'(i), 1'b0, 1'b0);
        check("full_ready", 32'(BUFFER_READY), 32'd0);
        cycle(1'b1, 9'h1FF, 1'b1, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("count_63", 32'(count), 32'd63);
        cycle(1'b0, 9'h000, 1'b0, 1'b0);
        check("ovf_one_cycle", 32'(overflow), 32'd0);

        // Drain, then run write+pop across the pointer wrap at depth 10
        repeat (63) cycle(1'b0, 9'h000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 9'(i), 1'b0, 1'b0);
        for (int i = 10; i < 110; i++) cycle(1'b1, 9'(i), 1'b1, 1'b0);
        check("wrap_count", 32'(count), 32'd10);
        repeat (10) cycle(1'b0, 9'h000, 1'b1, 1'b0);

        // Flush with 20 entries including 2 EEPs, concurrent write and pop ignored
        for (int i = 0; i < 20; i++)
            cycle(1'b1, (i == 7 || i == 15) ? SPW_EEP : 9'(8'(i + 8'h30)), 1'b0, 1'b0);
        check("pkt_before_flush", 32'(pkt_count), 32'd2);
        cycle(1'b1, 9'h055, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(RD_VALID), 32'd0);
        cycle(1'b0, 9'h000, 1'b0, 1'b0);
        check("flush_write_dropped", 32'(count), 32'd0);

        // Mid-stream reset with 30 entries
        for (int i = 0; i < 30; i++) cycle(1'b1, (i == 12) ? SPW_EOP : 9'(i), 1'b0, 1'b0);
        RESETn = 1'b0;
        BUFFER_WRITE = 1'b1;
        RX_DATA = 9'h0AA;
        @(posedge CLOCK);
        #1;
        RESETn = 1'b1;
        BUFFER_WRITE = 1'b0;
        RX_DATA = 9'bx;
        sb.delete();
        m_pkt = 0;
        m_ovf = 1'b0;
        check_state();
        cycle(1'b1, SPW_EEP, 1'b0, 1'b0);
        check("eep_after_reset", 32'(RD_DATA), 32'h101);
        check("pkt_after_reset", 32'(pkt_count), 32'd1);
        cycle(1'b0, 9'h000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
